// File: rtl/ncl_count_reader_if.sv
// Ring-side dual-rail handshake plus the synchronous valid/ready word output of ncl_count_reader.
// The master modport is the reader; the slave modport is the ring/monitor side.
interface ncl_count_reader_if #(
  parameter int DIGITS = 32
);
  logic [2*DIGITS-1:0] digits_in;
  logic                digits_comp;
  logic [DIGITS-1:0]   value;
  logic                value_valid;
  logic                out_ready;

  modport master (
    input  digits_in,
    input  out_ready,
    output digits_comp,
    output value,
    output value_valid
  );

  modport slave (
    output digits_in,
    output out_ready,
    input  digits_comp,
    input  value,
    input  value_valid
  );
endinterface

// File: rtl/ncl_count_reader.sv
// Reads NCL counter wavefronts into binary words, checks +1 sequencing and illegal rail codes.
// Pins to value_valid takes SYNC_STAGES+1 edges; the ring is held in DATA until out_ready accepts.
module ncl_count_reader #(
  parameter int DIGITS      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                init_n,
  ncl_count_reader_if.master  bus,
  output logic                seq_err,
  output logic                rail_err,
  output logic [15:0]         word_count
);

  typedef enum logic [1:0] {
    WAIT_DATA = 2'd0,
    HOLD      = 2'd1,
    WAIT_NULL = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [2*DIGITS-1:0] sync_q [SYNC_STAGES];
  logic [2*DIGITS-1:0] sync_d [SYNC_STAGES];
  logic [DIGITS-1:0]   value_q, value_d;
  logic                value_valid_q, value_valid_d;
  logic                digits_comp_q, digits_comp_d;
  logic                have_prev_q, have_prev_d;
  logic                seq_err_q, seq_err_d;
  logic                rail_err_q, rail_err_d;
  logic [15:0]         word_count_q, word_count_d;

  logic [2*DIGITS-1:0] s;
  logic [DIGITS-1:0]   s_word;
  logic                complete;
  logic                all_null;
  logic                any_illegal;

  always_comb begin
    sync_d[0] = bus.digits_in;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    complete    = 1'b1;
    all_null    = 1'b1;
    any_illegal = 1'b0;
    s_word      = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!s[2*i] && !s[2*i+1]) complete = 1'b0;
      if (s[2*i] || s[2*i+1])   all_null = 1'b0;
      if (s[2*i] && s[2*i+1])   any_illegal = 1'b1;
      s_word[i] = s[2*i+1];
    end
  end

  // value_q doubles as the previous word for the sequence check: it only
  // changes at capture, so between captures it is exactly the last word seen.
  always_comb begin
    state_d       = state_q;
    value_d       = value_q;
    value_valid_d = value_valid_q;
    digits_comp_d = digits_comp_q;
    have_prev_d   = have_prev_q;
    seq_err_d     = seq_err_q;
    rail_err_d    = rail_err_q | any_illegal;
    word_count_d  = word_count_q;
    case (state_q)
      WAIT_DATA: begin
        if (complete && !any_illegal) begin
          if (have_prev_q && (s_word != value_q + DIGITS'(1))) seq_err_d = 1'b1;
          value_d       = s_word;
          value_valid_d = 1'b1;
          have_prev_d   = 1'b1;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          value_valid_d = 1'b0;
          digits_comp_d = 1'b1;
          word_count_d  = word_count_q + 16'd1;
          state_d       = WAIT_NULL;
        end
      end
      WAIT_NULL: begin
        if (all_null) begin
          digits_comp_d = 1'b0;
          state_d       = WAIT_DATA;
        end
      end
      default: begin
        state_d = WAIT_DATA;
      end
    endcase
  end

  // digits_comp has its own flop so the ring never sees a decode glitch.
  always_ff @(posedge clk) begin
    if (!init_n) begin
      state_q       <= WAIT_DATA;
      value_q       <= '0;
      value_valid_q <= 1'b0;
      digits_comp_q <= 1'b0;
      have_prev_q   <= 1'b0;
      seq_err_q     <= 1'b0;
      rail_err_q    <= 1'b0;
      word_count_q  <= '0;
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      state_q       <= state_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      digits_comp_q <= digits_comp_d;
      have_prev_q   <= have_prev_d;
      seq_err_q     <= seq_err_d;
      rail_err_q    <= rail_err_d;
      word_count_q  <= word_count_d;
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
    end
  end

  assign bus.value       = value_q;
  assign bus.value_valid = value_valid_q;
  assign bus.digits_comp = digits_comp_q;
  assign seq_err         = seq_err_q;
  assign rail_err        = rail_err_q;
  assign word_count      = word_count_q;

endmodule

// File: tb/tb_ncl_count_reader.sv
// Self-checking bench for ncl_count_reader: vector table, handshake corner cases, randomized wavefronts.
module tb_ncl_count_reader;
  localparam int D = 32;

  logic        clk;
  logic        init_n;
  logic        seq_err;
  logic        rail_err;
  logic [15:0] word_count;

  int vectors;
  int miscompares;

  ncl_count_reader_if #(.DIGITS(D)) bus ();

  ncl_count_reader #(.DIGITS(D), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .init_n     (init_n),
    .bus        (bus.master),
    .seq_err    (seq_err),
    .rail_err   (rail_err),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1);
  end

  typedef struct {
    bit          rst_before;
    logic [31:0] word;
    logic        exp_seq_err;
    logic [15:0] exp_count;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [2*D-1:0] enc(input logic [D-1:0] w);
    logic [2*D-1:0] r;
    for (int i = 0; i < D; i++) r[2*i +: 2] = w[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input bit clear_ring);
    if (clear_ring) bus.digits_in = '0;
    bus.out_ready = 1'b0;
    init_n = 1'b0;
    step();
    step();
    init_n = 1'b1;
  endtask

  task automatic wait_vld(input string nm);
    int n = 0;
    while (bus.value_valid !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    chk(nm, 64'(bus.value_valid), 64'd1);
  endtask

  task automatic wait_comp_low(input string nm);
    int n = 0;
    while (bus.digits_comp !== 1'b0 && n < 60) begin
      step();
      n++;
    end
    chk(nm, 64'(bus.digits_comp), 64'd0);
  endtask

  task automatic handshake_and_null();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    bus.digits_in = '0;
    wait_comp_low("null_timeout");
  endtask

  // Reference model state for the randomized run
  logic [31:0] m_prev;
  bit          m_have;
  logic        m_seq;
  logic [15:0] m_cnt;

  initial begin
    logic [2*D-1:0] v;
    logic [31:0]    w;
    logic [D-1:0]   mask;
    vectors     = 0;
    miscompares = 0;
    init_n        = 1'b1;
    bus.digits_in = '0;
    bus.out_ready = 1'b0;

    tbl[0] = '{1'b1, 32'h0000_0005, 1'b0, 16'd1};
    tbl[1] = '{1'b1, 32'hFFFF_FFFE, 1'b0, 16'd1};
    tbl[2] = '{1'b0, 32'hFFFF_FFFF, 1'b0, 16'd2};
    tbl[3] = '{1'b0, 32'h0000_0000, 1'b0, 16'd3};
    tbl[4] = '{1'b1, 32'h0000_0005, 1'b0, 16'd1};
    tbl[5] = '{1'b0, 32'h0000_0007, 1'b1, 16'd2};
    tbl[6] = '{1'b0, 32'h0000_0008, 1'b1, 16'd3};
    tbl[7] = '{1'b0, 32'h0000_0009, 1'b1, 16'd4};

    // Reset state
    do_reset(1'b1);
    chk("rst_comp",  64'(bus.digits_comp), 64'd0);
    chk("rst_value", 64'(bus.value), 64'd0);
    chk("rst_vld",   64'(bus.value_valid), 64'd0);
    chk("rst_seq",   64'(seq_err), 64'd0);
    chk("rst_rail",  64'(rail_err), 64'd0);
    chk("rst_cnt",   64'(word_count), 64'd0);

    // Capture latency and handshake timing
    bus.digits_in = enc(32'h5);
    step();
    step();
    chk("lat_vld_edge2", 64'(bus.value_valid), 64'd0);
    step();
    chk("lat_vld_edge3", 64'(bus.value_valid), 64'd1);
    chk("lat_value", 64'(bus.value), 64'h5);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_comp", 64'(bus.digits_comp), 64'd0);
      chk("hold_value", 64'(bus.value), 64'h5);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("hs_comp_rise", 64'(bus.digits_comp), 64'd1);
    chk("hs_vld_clear", 64'(bus.value_valid), 64'd0);
    chk("hs_cnt", 64'(word_count), 64'd1);
    bus.digits_in = '0;
    step();
    step();
    chk("null_comp_edge2", 64'(bus.digits_comp), 64'd1);
    step();
    chk("null_comp_edge3", 64'(bus.digits_comp), 64'd0);
    chk("null_seq", 64'(seq_err), 64'd0);

    // Vector table: sequencing, wrap, sticky seq_err
    foreach (tbl[k]) begin
      if (tbl[k].rst_before) do_reset(1'b1);
      bus.digits_in = enc(tbl[k].word);
      wait_vld("tbl_vld_timeout");
      chk("tbl_value", 64'(bus.value), 64'(tbl[k].word));
      chk("tbl_seq", 64'(seq_err), 64'(tbl[k].exp_seq_err));
      handshake_and_null();
      chk("tbl_cnt", 64'(word_count), 64'(tbl[k].exp_count));
    end

    // Illegal code on digit 3 blocks capture until corrected
    do_reset(1'b1);
    v = enc(32'h8);
    v[7:6] = 2'b11;
    bus.digits_in = v;
    repeat (8) step();
    chk("rail_err_set", 64'(rail_err), 64'd1);
    chk("rail_no_capture", 64'(bus.value_valid), 64'd0);
    bus.digits_in = enc(32'h8);
    wait_vld("rail_vld_timeout");
    chk("rail_fix_value", 64'(bus.value), 64'h8);
    chk("rail_err_sticky", 64'(rail_err), 64'd1);
    handshake_and_null();

    // Reset while in WAIT_NULL with DATA still on the ring
    do_reset(1'b1);
    bus.digits_in = enc(32'd21);
    wait_vld("rw_vld_timeout");
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("rw_comp_high", 64'(bus.digits_comp), 64'd1);
    init_n = 1'b0;
    step();
    chk("rw_comp_drop", 64'(bus.digits_comp), 64'd0);
    init_n = 1'b1;
    wait_vld("rw_recap_timeout");
    chk("rw_recap_value", 64'(bus.value), 64'd21);
    chk("rw_recap_seq", 64'(seq_err), 64'd0);
    chk("rw_recap_cnt", 64'(word_count), 64'd0);
    handshake_and_null();

    // Randomized wavefronts with ragged digit arrival and departure
    do_reset(1'b1);
    m_have = 1'b0;
    m_seq  = 1'b0;
    m_cnt  = 16'd0;
    m_prev = 32'hFFFF_FFF0;
    for (int n = 0; n < 120; n++) begin
      w = ($urandom_range(0, 7) == 0) ? 32'($urandom) : m_prev + 32'd1;
      if (m_have && w != m_prev + 32'd1) m_seq = 1'b1;
      m_prev = w;
      m_have = 1'b1;
      m_cnt  = m_cnt + 16'd1;

      mask = '0;
      while (mask != '1) begin
        for (int i = 0; i < D; i++) if ($urandom_range(0, 2) == 0) mask[i] = 1'b1;
        v = enc(w);
        for (int i = 0; i < D; i++) if (!mask[i]) v[2*i +: 2] = 2'b00;
        bus.digits_in = v;
        step();
      end
      wait_vld("rnd_vld_timeout");
      chk("rnd_value", 64'(bus.value), 64'(w));
      chk("rnd_seq", 64'(seq_err), 64'(m_seq));
      repeat ($urandom_range(0, 3)) step();
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      chk("rnd_comp", 64'(bus.digits_comp), 64'd1);
      chk("rnd_cnt", 64'(word_count), 64'(m_cnt));

      v = bus.digits_in;
      while (v != '0) begin
        for (int i = 0; i < D; i++) if ($urandom_range(0, 2) == 0) v[2*i +: 2] = 2'b00;
        bus.digits_in = v;
        step();
      end
      wait_comp_low("rnd_null_timeout");
    end
    chk("rnd_rail_clean", 64'(rail_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ncl_count_reader.md
Name: ncl_count_reader

Overview:
- Clocked consumer for the dual-rail NCL counter ring. It reads the DIGITS sum digits of the counter and drives their shared completion (acknowledge) signal through a 4-phase return-to-NULL handshake.
- Converts each complete DATA wavefront to a binary word and presents it on a valid/ready interface.
- Checks that successive words increment by exactly 1, and flags illegal rail codes.
- Sits at the boundary between the self-timed counter array and synchronous test/monitor logic.

Parameters:
- DIGITS, 32, number of dual-rail digits, i.e. the counter width in bits.
- SYNC_STAGES, 2, synchronizer flops per input rail; legal range 2..4.

Ports:
- clk  input  1  system clock.
- init_n  input  1  synchronous active-low reset.
- digits_in  input  2*DIGITS  dual-rail digits. Digit i uses bits [2i+1:2i]: rail 1 is TRUE, rail 0 is FALSE, 00 is NULL. Asynchronous to clk.
- digits_comp  output  1  completion to the ring. 1 means DATA accepted, request NULL. 0 means NULL seen, request DATA.
- value  output  DIGITS  captured binary word; bit i is rail 1 of digit i.
- value_valid  output  1  value holds an unconsumed word.
- out_ready  input  1  downstream accepts value when value_valid and out_ready are both 1 on a clk edge.
- seq_err  output  1  sticky: a word did not equal the previous word + 1.
- rail_err  output  1  sticky: some synchronized digit showed 11.
- word_count  output  16  number of accepted words, wraps at 2^16.

Behaviour:
- Reset (init_n=0 at a clk edge):
  - digits_comp=0, value=0, value_valid=0, seq_err=0, rail_err=0, word_count=0.
  - All synchronizer flops cleared; FSM enters WAIT_DATA; the "have_prev" flag is cleared.
  - Reset mid-handshake drops digits_comp at once. If the ring still holds DATA, that wavefront is recaptured normally after reset and is not sequence-checked.
- Synchronization:
  - Each rail passes through SYNC_STAGES flops. All decode uses only the synchronized view s.
  - Dual-rail monotonicity makes the multi-bit sync safe. Rails only rise while digits_comp=0 and only fall while digits_comp=1, so once every digit of s is non-NULL the code is final.
- Decode:
  - complete = every digit of s is non-NULL.
  - all_null = every digit of s is 00.
  - any_illegal = some digit of s is 11.
- FSM:
  - WAIT_DATA (digits_comp=0): when complete and not any_illegal, capture value from rail 1 of each digit, set value_valid=1 on the next edge, go to HOLD. Partial DATA means wait, with no timeout.
  - HOLD (digits_comp=0, value_valid=1): on the out_ready handshake edge, clear value_valid, set digits_comp=1, increment word_count, go to WAIT_NULL. value stays stable until then.
  - WAIT_NULL (digits_comp=1): when all_null, set digits_comp=0 and go to WAIT_DATA. Partial NULL means wait.
- Latency:
  - DATA change at the pins to value_valid: SYNC_STAGES+1 edges.
  - Handshake to digits_comp rise: 1 edge.
  - all_null visible in s to digits_comp fall: 1 edge.
- Sequence check at capture:
  - If have_prev and the captured word != prev + 1 mod 2^DIGITS, set seq_err.
  - After the check, prev = captured word and have_prev = 1.
  - Wrap from all-ones to 0 is legal.
- rail_err:
  - Set in any state when any_illegal holds.
  - While any_illegal holds, WAIT_DATA does not capture. The FSM leaves WAIT_DATA only once the code is legal.
- No simultaneous events: WAIT_DATA and WAIT_NULL are exclusive, so capture and NULL detection never coincide.

Test Plan:
- Reset, then drive digits_in to DATA 0x00000005 (for each digit, 01 for 0, 10 for 1):
  - value_valid rises 3 edges later with value=0x00000005.
  - digits_comp stays 0 while out_ready=0.
- From the previous state, raise out_ready for 1 cycle, then drive all NULL:
  - digits_comp=1 the next edge, then 0 three edges after NULL is applied.
  - word_count=1, seq_err=0.
- Drive wavefronts 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 with full handshakes:
  - seq_err stays 0 and word_count=3.
- Drive 5 then 7:
  - seq_err=1 after the second capture and stays 1 through later correct words until reset.
- Drive digit 3 = 11 with the other digits valid:
  - rail_err=1 and no capture; correcting digit 3 to 10 produces a capture.
- Assert init_n=0 during WAIT_NULL with DATA still applied:
  - digits_comp=0 the next edge and the word is recaptured.
  - seq_err is not set on that capture.
